// File: rtl/pn_sched_pkg.sv
// Shared types and helpers for the pn_sched permutation-network scheduler.
package pn_sched_pkg;

  typedef logic [1:0] port_t;

  localparam int unsigned TimeWidthDflt = 8;

  localparam int unsigned NumPorts = 4;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    popcnt4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/pn_pair_arb.sv
// Combinational oldest-first 2x2 arbiter: the winner lands on the output index equal to
// its dest bit sel_i; the loser takes the other output. Ties never swap.
module pn_pair_arb
  import pn_sched_pkg::*;
#(
  parameter int unsigned     TW      = 8,
  parameter logic [TW-1:0]   MaxTime = '1
) (
  input  logic [TW-1:0] a_time_i,
  input  port_t         a_dest_i,
  input  port_t         a_src_i,
  input  logic [TW-1:0] b_time_i,
  input  port_t         b_dest_i,
  input  port_t         b_src_i,
  input  logic          sel_i,
  output logic [TW-1:0] o0_time_o,
  output port_t         o0_dest_o,
  output port_t         o0_src_o,
  output logic [TW-1:0] o1_time_o,
  output port_t         o1_dest_o,
  output port_t         o1_src_o
);

  logic [TW-1:0] key_a, key_b;
  logic          b_wins, mode, swap;

  always_comb begin
    // Empty slots (time 0) rank as the youngest possible flit.
    key_a  = (a_time_i == '0) ? MaxTime : a_time_i;
    key_b  = (b_time_i == '0) ? MaxTime : b_time_i;
    b_wins = key_b < key_a;
    mode   = b_wins ? b_dest_i[sel_i] : a_dest_i[sel_i];
    swap   = mode ? (key_a < key_b) : (key_b < key_a);
    if (swap) begin
      o0_time_o = b_time_i;
      o0_dest_o = b_dest_i;
      o0_src_o  = b_src_i;
      o1_time_o = a_time_i;
      o1_dest_o = a_dest_i;
      o1_src_o  = a_src_i;
    end else begin
      o0_time_o = a_time_i;
      o0_dest_o = a_dest_i;
      o0_src_o  = a_src_i;
      o1_time_o = b_time_i;
      o1_dest_o = b_dest_i;
      o1_src_o  = b_src_i;
    end
  end

endmodule

// File: rtl/pn_sched.sv
// Two-stage 4-port permutation-network scheduler: stage 1 steers on dest bit 1, stage 2 on
// dest bit 0, with a saturating count of deflected flits leaving the network.
module pn_sched
  import pn_sched_pkg::*;
#(
  parameter int unsigned TW = TimeWidthDflt,
  parameter int unsigned CW = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [4*TW-1:0]   in_time,
  input  logic [7:0]        in_dest,
  input  logic              cnt_clr,
  output logic              out_valid,
  output logic [4*TW-1:0]   out_time,
  output logic [7:0]        out_src,
  output logic [3:0]        out_defl,
  output logic [CW-1:0]     defl_cnt
);

  localparam logic [TW-1:0] MaxTime = '1;
  localparam logic [CW-1:0] CntMax = '1;

  logic [3:0][TW-1:0] in_time_a;
  logic [3:0][1:0]    in_dest_a;

  // Stage-1 arbiter outputs, index order {B.out1, B.out0, A.out1, A.out0}.
  logic [3:0][TW-1:0] st1_time;
  logic [3:0][1:0]    st1_dest, st1_src;

  // Stage-2 arbiter outputs, index = output port.
  logic [3:0][TW-1:0] st2_time;
  logic [3:0][1:0]    st2_dest, st2_src;
  logic [3:0]         st2_defl;

  logic               s1_valid_d, s1_valid_q;
  logic [3:0][TW-1:0] s1_time_d, s1_time_q;
  logic [3:0][1:0]    s1_dest_d, s1_dest_q;
  logic [3:0][1:0]    s1_src_d, s1_src_q;

  logic               out_valid_d, out_valid_q;
  logic [3:0][TW-1:0] out_time_d, out_time_q;
  logic [3:0][1:0]    out_src_d, out_src_q;
  logic [3:0]         out_defl_d, out_defl_q;

  logic [CW-1:0]      cnt_d, cnt_q;
  logic [CW:0]        cnt_sum;

  assign in_time_a = in_time;
  assign in_dest_a = in_dest;

  pn_pair_arb #(.TW(TW), .MaxTime(MaxTime)) u_arb_a (
    .a_time_i  (in_time_a[0]),
    .a_dest_i  (in_dest_a[0]),
    .a_src_i   (2'd0),
    .b_time_i  (in_time_a[1]),
    .b_dest_i  (in_dest_a[1]),
    .b_src_i   (2'd1),
    .sel_i     (1'b1),
    .o0_time_o (st1_time[0]),
    .o0_dest_o (st1_dest[0]),
    .o0_src_o  (st1_src[0]),
    .o1_time_o (st1_time[1]),
    .o1_dest_o (st1_dest[1]),
    .o1_src_o  (st1_src[1])
  );

  pn_pair_arb #(.TW(TW), .MaxTime(MaxTime)) u_arb_b (
    .a_time_i  (in_time_a[2]),
    .a_dest_i  (in_dest_a[2]),
    .a_src_i   (2'd2),
    .b_time_i  (in_time_a[3]),
    .b_dest_i  (in_dest_a[3]),
    .b_src_i   (2'd3),
    .sel_i     (1'b1),
    .o0_time_o (st1_time[2]),
    .o0_dest_o (st1_dest[2]),
    .o0_src_o  (st1_src[2]),
    .o1_time_o (st1_time[3]),
    .o1_dest_o (st1_dest[3]),
    .o1_src_o  (st1_src[3])
  );

  // Pair C joins the two out0 legs (ports 0/1), pair D the two out1 legs (ports 2/3).
  pn_pair_arb #(.TW(TW), .MaxTime(MaxTime)) u_arb_c (
    .a_time_i  (s1_time_q[0]),
    .a_dest_i  (s1_dest_q[0]),
    .a_src_i   (s1_src_q[0]),
    .b_time_i  (s1_time_q[2]),
    .b_dest_i  (s1_dest_q[2]),
    .b_src_i   (s1_src_q[2]),
    .sel_i     (1'b0),
    .o0_time_o (st2_time[0]),
    .o0_dest_o (st2_dest[0]),
    .o0_src_o  (st2_src[0]),
    .o1_time_o (st2_time[1]),
    .o1_dest_o (st2_dest[1]),
    .o1_src_o  (st2_src[1])
  );

  pn_pair_arb #(.TW(TW), .MaxTime(MaxTime)) u_arb_d (
    .a_time_i  (s1_time_q[1]),
    .a_dest_i  (s1_dest_q[1]),
    .a_src_i   (s1_src_q[1]),
    .b_time_i  (s1_time_q[3]),
    .b_dest_i  (s1_dest_q[3]),
    .b_src_i   (s1_src_q[3]),
    .sel_i     (1'b0),
    .o0_time_o (st2_time[2]),
    .o0_dest_o (st2_dest[2]),
    .o0_src_o  (st2_src[2]),
    .o1_time_o (st2_time[3]),
    .o1_dest_o (st2_dest[3]),
    .o1_src_o  (st2_src[3])
  );

  always_comb begin
    for (int j = 0; j < NumPorts; j++) begin
      st2_defl[j] = (st2_time[j] != '0) && (st2_dest[j] != 2'(j));
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_time_d   = s1_time_q;
    s1_dest_d   = s1_dest_q;
    s1_src_d    = s1_src_q;
    out_valid_d = out_valid_q;
    out_time_d  = out_time_q;
    out_src_d   = out_src_q;
    out_defl_d  = out_defl_q;
    if (!stall) begin
      s1_valid_d  = in_valid;
      s1_time_d   = in_valid ? st1_time : '0;
      s1_dest_d   = in_valid ? st1_dest : '0;
      s1_src_d    = in_valid ? st1_src : '0;
      out_valid_d = s1_valid_q;
      out_time_d  = st2_time;
      out_src_d   = st2_src;
      out_defl_d  = st2_defl;
    end
  end

  // The count tracks the bundle being loaded into the output regs on the same edge.
  always_comb begin
    cnt_sum = {1'b0, cnt_q} + (CW + 1)'(popcnt4(st2_defl));
    cnt_d   = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!stall && s1_valid_q) begin
      cnt_d = cnt_sum[CW] ? CntMax : cnt_sum[CW-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_time_q   <= '0;
      s1_dest_q   <= '0;
      s1_src_q    <= '0;
      out_valid_q <= 1'b0;
      out_time_q  <= '0;
      out_src_q   <= '0;
      out_defl_q  <= '0;
      cnt_q       <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_time_q   <= s1_time_d;
      s1_dest_q   <= s1_dest_d;
      s1_src_q    <= s1_src_d;
      out_valid_q <= out_valid_d;
      out_time_q  <= out_time_d;
      out_src_q   <= out_src_d;
      out_defl_q  <= out_defl_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_time  = out_time_q;
  assign out_src   = out_src_q;
  assign out_defl  = out_defl_q;
  assign defl_cnt  = cnt_q;

endmodule

// File: tb/tb_pn_sched.sv
// Directed bench for pn_sched with TW=8; a second instance with a 2-bit counter
// exercises saturation alongside the main one.
module tb_pn_sched;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall;
  logic        in_valid;
  logic [31:0] in_time;
  logic [7:0]  in_dest;
  logic        cnt_clr;

  logic        out_valid, s_out_valid;
  logic [31:0] out_time, s_out_time;
  logic [7:0]  out_src, s_out_src;
  logic [3:0]  out_defl, s_out_defl;
  logic [15:0] defl_cnt;
  logic [1:0]  s_defl_cnt;

  int total = 0;
  int bad   = 0;
  int exp_cnt = 0;
  int exp_sat = 0;

  always #5 clk = ~clk;

  pn_sched #(.TW(8), .CW(16)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_time   (in_time),
    .in_dest   (in_dest),
    .cnt_clr   (cnt_clr),
    .out_valid (out_valid),
    .out_time  (out_time),
    .out_src   (out_src),
    .out_defl  (out_defl),
    .defl_cnt  (defl_cnt)
  );

  pn_sched #(.TW(8), .CW(2)) u_sat (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .in_valid  (in_valid),
    .in_time   (in_time),
    .in_dest   (in_dest),
    .cnt_clr   (cnt_clr),
    .out_valid (s_out_valid),
    .out_time  (s_out_time),
    .out_src   (s_out_src),
    .out_defl  (s_out_defl),
    .defl_cnt  (s_defl_cnt)
  );

  // Packed fields list slot/port 3 first, slot/port 0 last.
  typedef struct {
    string       name;
    logic [31:0] t;
    logic [7:0]  d;
    logic [31:0] et;
    logic [7:0]  es;
    logic [3:0]  ed;
    int          dc;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    in_valid = 1'b1;
    in_time  = v.t;
    in_dest  = v.d;
  endtask

  task automatic check_vec(input vec_t v, input bit add);
    if (add) begin
      exp_cnt = exp_cnt + v.dc;
      exp_sat = (exp_sat + v.dc > 3) ? 3 : exp_sat + v.dc;
    end
    chk({v.name, ".valid"}, 64'(out_valid), 64'd1);
    chk({v.name, ".time"}, 64'(out_time), 64'(v.et));
    chk({v.name, ".src"}, 64'(out_src), 64'(v.es));
    chk({v.name, ".defl"}, 64'(out_defl), 64'(v.ed));
    chk({v.name, ".cnt"}, 64'(defl_cnt), 64'(exp_cnt));
    chk({v.name, ".satcnt"}, 64'(s_defl_cnt), 64'(exp_sat));
  endtask

  task automatic check_idle(input string name);
    chk({name, ".valid"}, 64'(out_valid), 64'd0);
    chk({name, ".time"}, 64'(out_time), 64'd0);
    chk({name, ".src"}, 64'(out_src), 64'd0);
    chk({name, ".defl"}, 64'(out_defl), 64'd0);
  endtask

  initial begin
    vecs[0] = '{"ideal", {8'd8, 8'd7, 8'd6, 8'd5}, {2'd3, 2'd1, 2'd2, 2'd0},
                {8'd8, 8'd6, 8'd7, 8'd5}, {2'd3, 2'd1, 2'd2, 2'd0}, 4'b0000, 0};
    vecs[1] = '{"revdest", {8'd8, 8'd7, 8'd6, 8'd5}, {2'd0, 2'd1, 2'd2, 2'd3},
                {8'd5, 8'd8, 8'd7, 8'd6}, {2'd0, 2'd3, 2'd2, 2'd1}, 4'b0101, 2};
    vecs[2] = '{"conflict", {8'd0, 8'd0, 8'd9, 8'd3}, {2'd0, 2'd0, 2'd0, 2'd0},
                {8'd0, 8'd9, 8'd0, 8'd3}, {2'd3, 2'd1, 2'd2, 2'd0}, 4'b0100, 1};
    vecs[3] = '{"empty", {8'd0, 8'd0, 8'd4, 8'd0}, {2'd0, 2'd0, 2'd2, 2'd0},
                {8'd0, 8'd4, 8'd0, 8'd0}, {2'd3, 2'd1, 2'd2, 2'd0}, 4'b0000, 0};
    vecs[4] = '{"tie", {8'd7, 8'd7, 8'd7, 8'd7}, {2'd1, 2'd1, 2'd1, 2'd1},
                {8'd7, 8'd7, 8'd7, 8'd7}, {2'd3, 2'd1, 2'd2, 2'd0}, 4'b1101, 3};
    vecs[5] = '{"maxtime", {8'd0, 8'd0, 8'd0, 8'd255}, {2'd0, 2'd0, 2'd0, 2'd1},
                {8'd0, 8'd0, 8'd0, 8'd255}, {2'd3, 2'd1, 2'd2, 2'd0}, 4'b0001, 1};
    vecs[6] = '{"bwins", {8'd0, 8'd0, 8'd2, 8'd9}, {2'd0, 2'd0, 2'd1, 2'd0},
                {8'd0, 8'd9, 8'd2, 8'd0}, {2'd3, 2'd0, 2'd1, 2'd2}, 4'b0100, 1};

    reset_n  = 1'b0;
    stall    = 1'b0;
    in_valid = 1'b0;
    in_time  = '0;
    in_dest  = '0;
    cnt_clr  = 1'b0;
    tick();
    tick();
    check_idle("reset");
    chk("reset.cnt", 64'(defl_cnt), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;

    for (int i = 0; i < 7; i++) begin
      drive(vecs[i]);
      tick();
      in_valid = 1'b0;
      tick();
      check_vec(vecs[i], 1'b1);
    end
    tick();
    check_idle("bubble");

    // Stall mid-stream: stage 1 holds "empty" while outputs hold "conflict".
    drive(vecs[2]);
    tick();
    drive(vecs[3]);
    tick();
    check_vec(vecs[2], 1'b1);
    drive(vecs[4]);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_vec(vecs[2], 1'b0);
    end
    stall = 1'b0;
    tick();
    check_vec(vecs[3], 1'b1);
    in_valid = 1'b0;
    tick();
    check_vec(vecs[4], 1'b1);
    tick();
    check_idle("post_stall");

    // Clear coinciding with a three-deflection bundle reaching the outputs.
    drive(vecs[4]);
    tick();
    in_valid = 1'b0;
    cnt_clr  = 1'b1;
    tick();
    cnt_clr = 1'b0;
    exp_cnt = 0;
    exp_sat = 0;
    check_vec(vecs[4], 1'b0);

    // Asynchronous reset between edges with a bundle in each stage.
    drive(vecs[1]);
    tick();
    drive(vecs[6]);
    tick();
    check_vec(vecs[1], 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check_idle("async_rst");
    chk("async_rst.cnt", 64'(defl_cnt), 64'd0);
    chk("async_rst.satcnt", 64'(s_defl_cnt), 64'd0);
    exp_cnt = 0;
    exp_sat = 0;
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    tick();
    check_idle("discard");
    chk("discard.cnt", 64'(defl_cnt), 64'd0);

    // Saturation: 3 + 1 on the 2-bit counter stays at 3.
    drive(vecs[4]);
    tick();
    drive(vecs[2]);
    tick();
    check_vec(vecs[4], 1'b1);
    in_valid = 1'b0;
    tick();
    check_vec(vecs[2], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
